// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard with forwarding selects, load-use stall and flush.
// Optional stall counter: define HAZARD_STATS_EN.
module hazard_scoreboard #(
  parameter int DEPTH       = 3,
  parameter int REG_W       = 5,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_SLOTS = 1,
  parameter int SEL_W       = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_writes_rd,
  input  logic             id_is_load,
  input  logic             hold,
  input  logic             flush,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic             stall_id,
  output logic             bubble_ex
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_count
`endif
);

  logic [DEPTH:1]   r_vld;
  logic [DEPTH:1]   r_ld;
  logic [REG_W-1:0] r_rd [1:DEPTH];

  logic [SEL_W-1:0] w_sel_a;
  logic [SEL_W-1:0] w_sel_b;
  logic             w_hz_a;
  logic             w_hz_b;
  logic             w_stall;
  logic             w_push;

  // Scan oldest to youngest so the youngest match is the last one kept.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_hz_a  = 1'b0;
    w_hz_b  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_uses_rs1 && id_rs1 != '0 &&
          r_vld[k] && r_rd[k] == id_rs1) begin
        w_sel_a = SEL_W'(k);
        w_hz_a  = r_ld[k] && (k <= LOAD_LAT);
      end
      if (id_uses_rs2 && id_rs2 != '0 &&
          r_vld[k] && r_rd[k] == id_rs2) begin
        w_sel_b = SEL_W'(k);
        w_hz_b  = r_ld[k] && (k <= LOAD_LAT);
      end
    end
  end

  assign w_stall = ~reset &
                   ((id_valid & (w_hz_a | w_hz_b)) | hold);

  assign w_push = id_valid & id_writes_rd &
                  (id_rd != '0) & ~w_stall & ~flush;

  assign fwd_sel_a = (reset | w_hz_a) ? '0 : w_sel_a;
  assign fwd_sel_b = (reset | w_hz_b) ? '0 : w_sel_b;
  assign stall_id  = w_stall;
  assign bubble_ex = w_stall & ~hold & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else if (hold) begin
      if (flush) begin
        for (int k = 1; k <= FLUSH_SLOTS; k++)
          r_vld[k] <= 1'b0;
      end
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_rd[k]  <= r_rd[k-1];
      end
      r_vld[1] <= w_push;
      r_ld[1]  <= id_is_load;
      r_rd[1]  <= id_rd;
      // Later assignments override the freshly shifted slots.
      if (flush) begin
        for (int k = 1; k <= FLUSH_SLOTS; k++)
          r_vld[k] <= 1'b0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (w_stall && stall_count != '1)
      stall_count <= stall_count + 32'd1;
  end
`endif

endmodule
